// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: decodes the tohost exit protocol of rv32ui tests
// into sticky pass/fail/timeout/hang verdicts with run counters.
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned STALL_LIMIT    = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_strb,
  input  logic             retire,
  input  logic [31:0]      pc,
  output logic             done,
  output logic             pass,
  output logic [30:0]      fail_id,
  output logic             timeout,
  output logic             hang,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ST_LIM = CNT_W'(STALL_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [30:0]      fid_q, fid_d;

  logic             tohost_exit;
  logic             advance;
  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] ret_inc;
  logic [CNT_W-1:0] stall_nx;

  // st_valid gates everything so junk on the idle bus is harmless
  assign tohost_exit = st_valid
                     && (st_addr == TOHOST_ADDR)
                     && (st_strb == 4'hF)
                     && st_data[0];

  assign advance = retire && (pc != last_pc_q);

  assign cyc_inc = (cyc_q == CMAX) ? cyc_q : cyc_q + ONE;
  assign ret_inc = (ret_q == CMAX) ? ret_q : ret_q + ONE;

  always_comb begin
    stall_nx = stall_q;
    if (advance) begin
      stall_nx = '0;
    end else if (stall_q != CMAX) begin
      stall_nx = stall_q + ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    stall_d   = stall_q;
    last_pc_d = last_pc_q;
    fid_d     = fid_q;
    if (state_q == S_RUN) begin
      cyc_d   = cyc_inc;
      stall_d = stall_nx;
      if (retire) begin
        ret_d     = ret_inc;
        last_pc_d = pc;
      end
      if (tohost_exit) begin
        if (st_data == 32'h1) begin
          state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          fid_d   = st_data[31:1];
        end
      end else if (cyc_inc == TO_LIM) begin
        state_d = S_TIMEOUT;
      end else if (stall_nx == ST_LIM) begin
        state_d = S_HANG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      cyc_q     <= '0;
      ret_q     <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      fid_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
      fid_q     <= fid_d;
    end
  end

  assign done    = (state_q != S_RUN);
  assign pass    = (state_q == S_PASS);
  assign timeout = (state_q == S_TIMEOUT);
  assign hang    = (state_q == S_HANG);
  assign fail_id = fid_q;
  assign cycles  = cyc_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: randomized scoreboard bench comparing the
// monitor against a verdict-level reference model.
module tb_riscv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int unsigned TMO    = 5000;
  localparam int unsigned STL    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_strb = '0;
  logic        retire = 1'b0;
  logic [31:0] pc = '0;
  logic        done, pass, timeout, hang;
  logic [30:0] fail_id;
  logic [31:0] cycles, retired;

  riscv_test_monitor #(
    .TOHOST_ADDR(TOHOST),
    .TIMEOUT_CYCLES(TMO),
    .STALL_LIMIT(STL),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .st_valid(st_valid),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_strb(st_strb),
    .retire(retire),
    .pc(pc),
    .done(done),
    .pass(pass),
    .fail_id(fail_id),
    .timeout(timeout),
    .hang(hang),
    .cycles(cycles),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        pass;
    logic [30:0] fid;
    logic        tmo;
    logic        hng;
    logic [31:0] cyc;
    logic [31:0] ret;
    int          tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int test_no = 0;

  // Reference model: verdict name plus plain counters.
  // verdict: 0 running, 1 pass, 2 fail, 3 timeout, 4 hang
  int          m_verdict;
  int unsigned m_cyc, m_ret, m_noadv;
  logic [31:0] m_last_pc;
  logic [30:0] m_fid;

  function automatic void m_reset();
    m_verdict = 0;
    m_cyc     = 0;
    m_ret     = 0;
    m_noadv   = 0;
    m_last_pc = '0;
    m_fid     = '0;
  endfunction

  function automatic void m_clock(input logic v, input logic [31:0] a,
                                  input logic [31:0] d,
                                  input logic [3:0] s, input logic r,
                                  input logic [31:0] p);
    bit is_exit;
    if (m_verdict != 0) return;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (r && m_ret != 32'hFFFF_FFFF) m_ret++;
    if (r && p != m_last_pc) m_noadv = 0;
    else if (m_noadv != 32'hFFFF_FFFF) m_noadv++;
    if (r) m_last_pc = p;
    is_exit = v && a == TOHOST && s == 4'hF && d[0];
    if (is_exit) begin
      if (d == 32'h1) m_verdict = 1;
      else begin
        m_verdict = 2;
        m_fid = d[31:1];
      end
    end else if (m_cyc == TMO) m_verdict = 3;
    else if (m_noadv == STL) m_verdict = 4;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.done = (m_verdict != 0);
    e.pass = (m_verdict == 1);
    e.fid  = (m_verdict == 2) ? m_fid : 31'd0;
    e.tmo  = (m_verdict == 3);
    e.hng  = (m_verdict == 4);
    e.cyc  = m_cyc;
    e.ret  = m_ret;
    e.tag  = test_no;
    return e;
  endfunction

  task automatic check(input exp_t e, input string nm);
    checks++;
    if (done !== e.done || pass !== e.pass || fail_id !== e.fid ||
        timeout !== e.tmo || hang !== e.hng ||
        cycles !== e.cyc || retired !== e.ret) begin
      errors++;
      $display("FAIL %s t%0d got d%b p%b f%0d to%b h%b c%0d r%0d exp d%b p%b f%0d to%b h%b c%0d r%0d",
               nm, e.tag, done, pass, fail_id, timeout, hang, cycles,
               retired, e.done, e.pass, e.fid, e.tmo, e.hng, e.cyc,
               e.ret);
    end
  endtask

  // Monitor: each negedge shows the outputs after the preceding posedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e, "sb");
    end
  end

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic r, input logic [31:0] p);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_strb  = s;
    retire   = r;
    pc       = p;
    m_clock(v, a, d, s, r, p);
    q.push_back(snap());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst      = 1'b0;
    st_valid = 1'b0;
    retire   = 1'b0;
    m_reset();
    #1;
    check(snap(), "async_rst");
    q.push_back(snap());
  endtask

  // Idle bus carrying a tohost-looking pattern, which must be ignored.
  task automatic idle_retire(input logic [31:0] p);
    step(1'b0, TOHOST, 32'h1, 4'hF, 1'b1, p);
  endtask

  task automatic exit_wr(input logic [31:0] d, input logic r,
                         input logic [31:0] p);
    step(1'b1, TOHOST, d, 4'hF, r, p);
  endtask

  task automatic rnd_step(input int unsigned exit_pct);
    logic        v, r;
    logic [31:0] a, d, p;
    logic [3:0]  s;
    v = 1'($urandom_range(0, 1));
    a = 32'h2000 + ($urandom_range(0, 15) << 2);
    d = $urandom;
    s = 4'($urandom);
    if ($urandom_range(0, 99) < exit_pct) begin
      a = TOHOST;
      s = ($urandom_range(0, 3) != 0) ? 4'hF : s;
      d = ($urandom_range(0, 1) != 0) ? 32'h1 : d;
    end
    r = 1'($urandom_range(0, 1));
    p = 32'h8000_0000 + ($urandom_range(0, 3) << 2);
    step(v, a, d, s, r, p);
  endtask

  initial begin
    logic [31:0] npc;
    m_reset();

    // 1: ten distinct retires then pass; later traffic is ignored
    test_no = 1;
    do_reset();
    for (int i = 0; i < 10; i++) idle_retire(32'h8000_0000 + 4 * i);
    exit_wr(32'h1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) rnd_step(50);
    exit_wr(32'h7, 1'b1, 32'h8000_1000);

    // 2: fail with id 3, then a pass write changes nothing
    test_no = 2;
    do_reset();
    idle_retire(32'h8000_0000);
    exit_wr(32'h7, 1'b1, 32'h8000_0004);
    exit_wr(32'h1, 1'b1, 32'h8000_0008);
    for (int i = 0; i < 10; i++) rnd_step(50);

    // 3: non-exit tohost-ish writes
    test_no = 3;
    do_reset();
    step(1'b1, TOHOST, 32'h2, 4'hF, 1'b1, 32'h8000_0000);
    step(1'b1, TOHOST, 32'h1, 4'h3, 1'b1, 32'h8000_0004);
    step(1'b1, TOHOST + 4, 32'h1, 4'hF, 1'b1, 32'h8000_0008);
    step(1'b1, TOHOST, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'h0);
    step(1'b1, TOHOST, 32'h1, 4'h7, 1'b1, 32'h8000_000C);

    // 4a: timeout with PCs always advancing
    test_no = 4;
    do_reset();
    npc = 32'h8000_0000;
    for (int i = 0; i < TMO + 8; i++) begin
      npc += 4;
      if (i % 7 == 3)
        step(1'b1, 32'h2000, $urandom, 4'hF, 1'b1, npc);
      else
        idle_retire(npc);
    end

    // 4b: exit write lands on the timeout cycle and wins
    test_no = 5;
    do_reset();
    npc = 32'h8000_0000;
    for (int i = 0; i < TMO - 1; i++) begin
      npc += 4;
      idle_retire(npc);
    end
    exit_wr(32'h1, 1'b1, npc + 4);
    for (int i = 0; i < 4; i++) idle_retire(npc + 8 + 4 * i);

    // 5a: self-loop hangs
    test_no = 6;
    do_reset();
    for (int i = 0; i < STL + 10; i++) idle_retire(32'h8000_0040);

    // 5b: one new PC at cycle 63 restarts the stall count
    test_no = 7;
    do_reset();
    for (int i = 1; i <= 2 * STL + 10; i++) begin
      if (i == 63) idle_retire(32'h8000_0044);
      else idle_retire(32'h8000_0040);
    end

    // 5c: no retires at all also counts as stalling
    test_no = 8;
    do_reset();
    for (int i = 0; i < STL + 4; i++)
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    // 6: pass, async reset, counting restarts from 0
    test_no = 9;
    do_reset();
    for (int i = 0; i < 5; i++) idle_retire(32'h8000_0000 + 4 * i);
    exit_wr(32'h1, 1'b0, 32'h0);
    idle_retire(32'h8000_0100);
    do_reset();
    for (int i = 0; i < 6; i++) idle_retire(32'h8000_0200 + 4 * i);

    // randomized runs with occasional exit attempts
    for (int t = 0; t < 20; t++) begin
      test_no = 100 + t;
      do_reset();
      for (int i = 0; i < 120; i++) rnd_step(3);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d expected entries, required 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
